// File: rtl/vga_pkg.sv
// Shared video-path types and constants for the address generator and pixel output stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   game_state_e  - game state encodings (WAIT/INFORMATION/GAME/WIN/LOSE)
//   DETECT_NONE   - platform detect code meaning "no platform under this pixel"
//   rgb12_t       - 4:4:4 colour word, {r,g,b}
//   KEY_COLOR_DEF / BG_COLOR_DEF - default doodle colour key and its replacement
//   scale_chan()  - 4-bit channel brightness scaling used by the fade
package vga_pkg;

  typedef enum logic [2:0] {
    ST_WAIT        = 3'd0,
    ST_INFORMATION = 3'd1,
    ST_GAME        = 3'd2,
    ST_WIN         = 3'd3,
    ST_LOSE        = 3'd4
  } game_state_e;

  localparam logic [2:0] DETECT_NONE = 3'd5;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t KEY_COLOR_DEF = 12'h0F0;
  localparam rgb12_t BG_COLOR_DEF  = 12'h000;

  // (c * (lvl+1)) >> 4 in 8 bits. Level 15 multiplies by 16, so the
  // channel passes through unchanged; level 0 maps everything below 16 to 0.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = {4'b0000, c} * ({4'b0000, lvl} + 8'd1);
    return prod[7:4];
  endfunction

endpackage

// File: rtl/vga_pixel_out_if.sv
// Bundle of the pixel-output stage's video inputs (timing, flags, ROM word) and VGA pin outputs.
// Latency: n/a (wires only).
// Backpressure: none; the video stream is free-running, one pixel per clk.
//
// master: upstream side (VGA controller, address generator, ROM) drives the inputs, sees the pins.
// slave : vga_pixel_out consumes the inputs and drives vga_r/g/b, hsync, vsync and detect_out.
interface vga_pixel_out_if;
  import vga_pkg::*;

  logic       valid_in;       // display enable, aligned with h_cnt/v_cnt
  logic       hsync_in;       // active-low, aligned with h_cnt/v_cnt
  logic       vsync_in;       // active-low, aligned with h_cnt/v_cnt
  logic [2:0] state;          // game state
  logic       invincible;     // doodle invincibility flag, used undelayed
  logic       detect_doodle;  // one cycle behind h_cnt
  logic [2:0] detect;         // platform type 0..4, DETECT_NONE otherwise; one cycle behind h_cnt
  rgb12_t     rom_data;       // ROM word for the pixel now leaving the pipe

  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync;
  logic       vsync;
  logic [2:0] detect_out;     // platform type re-aligned with the colour pins

  modport master (
    output valid_in, hsync_in, vsync_in, state, invincible, detect_doodle, detect, rom_data,
    input  vga_r, vga_g, vga_b, hsync, vsync, detect_out
  );

  modport slave (
    input  valid_in, hsync_in, vsync_in, state, invincible, detect_doodle, detect, rom_data,
    output vga_r, vga_g, vga_b, hsync, vsync, detect_out
  );

endinterface

// File: rtl/vga_pixel_out_pipe_delay.sv
// pipe_delay: fixed-depth shift register with synchronous reset to a chosen value.
// Latency: DEPTH clk cycles from din to dout.
// Backpressure: none; shifts every cycle.
//
// Ports: clk, rst (sync, active-high), din[WIDTH], dout[WIDTH].
module pipe_delay #(
  parameter int                WIDTH   = 1,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// Final video stage: realigns sync/blank/flags to ROM latency, colour-keys and blinks the doodle, drives VGA pins.
// Latency: ROM_LAT+1 clk from valid/sync sampling to pins (flags enter one cycle late, so they get ROM_LAT).
// Backpressure: none; free-running pixel stream, one pixel per clk.
//
// Ports: clk, rst (sync, active-high), bus (vga_pixel_out_if.slave).
// Optional feature: define VGA_FADE_EN to add the fade-in after every game-state change.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int     ROM_LAT   = 2,
  parameter rgb12_t KEY_COLOR = KEY_COLOR_DEF,
  parameter rgb12_t BG_COLOR  = BG_COLOR_DEF,
  parameter int     BLINK_BIT = 3
) (
  input  logic           clk,
  input  logic           rst,
  vga_pixel_out_if.slave bus
);

  // Syncs and enable are aligned with h_cnt; the ROM word shows up ROM_LAT
  // cycles after the address register, i.e. one cycle later than that.
  localparam int PIPE = ROM_LAT + 1;

  // ---------------------------------------------------------------
  // Alignment pipes
  // ---------------------------------------------------------------
  logic [2:0] sync_pipe;   // {valid, hsync, vsync}
  logic [3:0] flag_pipe;   // {doodle, detect}

  pipe_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE),
    .RST_VAL (3'b011)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.valid_in, bus.hsync_in, bus.vsync_in}),
    .dout (sync_pipe)
  );

  pipe_delay #(
    .WIDTH   (4),
    .DEPTH   (ROM_LAT),
    .RST_VAL ({1'b0, DETECT_NONE})
  ) u_flag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.detect_doodle, bus.detect}),
    .dout (flag_pipe)
  );

  logic       valid_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       doodle_d;
  logic [2:0] detect_d;

  assign valid_d  = sync_pipe[2];
  assign hsync_d  = sync_pipe[1];
  assign vsync_d  = sync_pipe[0];
  assign doodle_d = flag_pipe[3];
  assign detect_d = flag_pipe[2:0];

  // ---------------------------------------------------------------
  // Frame counter, stepped on the undelayed vsync falling edge
  // ---------------------------------------------------------------
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vsync_prev_q, vsync_prev_d;
  logic       vsync_fall;

  // vsync_prev resets high so a vsync_in already low at reset release is not
  // mistaken for a new frame.
  assign vsync_fall = vsync_prev_q & ~bus.vsync_in;

  always_comb begin
    vsync_prev_d = bus.vsync_in;
    frame_cnt_d  = frame_cnt_q + {7'd0, vsync_fall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= 1'b1;
      frame_cnt_q  <= 8'd0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // Colour select on the realigned stream
  // ---------------------------------------------------------------
  logic [11:0] rom_raw;
  rgb12_t      pix_sel;
  rgb12_t      pix_out;

  assign rom_raw = bus.rom_data;

  // The key test sits above the blink so keyed pixels never invert.
  // invincible is deliberately not delayed: a mid-frame change shows on the next pixel.
  always_comb begin
    pix_sel = '0;
    if (!valid_d) begin
      pix_sel = '0;
    end else if (doodle_d && (bus.rom_data == KEY_COLOR)) begin
      pix_sel = BG_COLOR;
    end else if (doodle_d && bus.invincible && frame_cnt_q[BLINK_BIT]) begin
      pix_sel = ~rom_raw;
    end else begin
      pix_sel = bus.rom_data;
    end
  end

`ifdef VGA_FADE_EN
  // ---------------------------------------------------------------
  // State-change fade: brightness restarts at level 0 and climbs one
  // step per frame up to 15 (pass-through).
  // ---------------------------------------------------------------
  logic [3:0] fade_lvl_q, fade_lvl_d;
  logic [2:0] prev_state_q, prev_state_d;

  // A state change in the same cycle as a vsync edge leaves the level at 0.
  always_comb begin
    fade_lvl_d   = fade_lvl_q;
    prev_state_d = prev_state_q;
    if (bus.state != prev_state_q) begin
      fade_lvl_d   = 4'd0;
      prev_state_d = bus.state;
    end else if (vsync_fall && (fade_lvl_q != 4'hF)) begin
      fade_lvl_d = fade_lvl_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fade_lvl_q   <= 4'hF;
      prev_state_q <= bus.state;
    end else begin
      fade_lvl_q   <= fade_lvl_d;
      prev_state_q <= prev_state_d;
    end
  end

  always_comb begin
    pix_out.r = scale_chan(pix_sel.r, fade_lvl_q);
    pix_out.g = scale_chan(pix_sel.g, fade_lvl_q);
    pix_out.b = scale_chan(pix_sel.b, fade_lvl_q);
  end
`else
  assign pix_out = pix_sel;
`endif

  // ---------------------------------------------------------------
  // Output register: pins, syncs and the realigned platform type
  // ---------------------------------------------------------------
  rgb12_t     rgb_q, rgb_d;
  logic       hsync_q, hsync_d_out;
  logic       vsync_q, vsync_d_out;
  logic [2:0] detect_out_q, detect_out_d;

  always_comb begin
    rgb_d        = pix_out;
    hsync_d_out  = hsync_d;
    vsync_d_out  = vsync_d;
    detect_out_d = detect_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      detect_out_q <= DETECT_NONE;
    end else begin
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d_out;
      vsync_q      <= vsync_d_out;
      detect_out_q <= detect_out_d;
    end
  end

  assign bus.vga_r      = rgb_q.r;
  assign bus.vga_g      = rgb_q.g;
  assign bus.vga_b      = rgb_q.b;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.detect_out = detect_out_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: directed scenarios then random stimulus, scored against a history-based model.
// Latency: model predicts pins ROM_LAT+1 samples after valid/sync, ROM_LAT after flags, same sample for ROM/invincible.
// Backpressure: none; one expected pixel is queued per clock and popped by the monitor.
module tb_vga_pixel_out;

  localparam int          ROM_LAT   = 2;
  localparam int          PIPE      = ROM_LAT + 1;
  localparam int          BLINK_BIT = 3;
  localparam int          NCYC      = 4000;
  localparam logic [11:0] KEY       = 12'h0F0;
  localparam logic [11:0] BG        = 12'h000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_pixel_out_if bus();

  vga_pixel_out #(
    .ROM_LAT   (ROM_LAT),
    .KEY_COLOR (KEY),
    .BG_COLOR  (BG),
    .BLINK_BIT (BLINK_BIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          idx;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [2:0]  det;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Everything the DUT sampled, indexed by sample number.
  logic        h_rst [NCYC];
  logic        h_v   [NCYC];
  logic        h_hs  [NCYC];
  logic        h_vs  [NCYC];
  logic        h_dd  [NCYC];
  logic [2:0]  h_det [NCYC];
  int          k = 0;

  // Frame / fade bookkeeping of the reference model.
  logic [7:0]  m_frames = 8'd0;
  bit          m_vs_prev = 1'b1;
  int          m_lvl = 15;
  logic [2:0]  m_state = 3'd0;

  function automatic bit rst_within(input int lo, input int hi);
    for (int j = lo; j <= hi; j++) begin
      if (j < 0) return 1'b1;
      if (h_rst[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] fade(input logic [3:0] c, input int lvl);
    int v;
    v = (int'(c) * (lvl + 1)) / 16;
    return v[3:0];
  endfunction

  // Drive one pixel clock of inputs, queue the pins expected right after this edge.
  task automatic step(input bit r, input bit v, input bit hs, input bit vs,
                      input logic [2:0] st, input bit inv, input bit dd,
                      input logic [2:0] det, input logic [11:0] rom);
    exp_t        e;
    bit          pv, ph, pvs, pd, fall;
    logic [2:0]  pdet;
    logic [11:0] c;
    @(negedge clk);
    if (k >= NCYC) begin
      $display("FAIL history_overflow k=%0d limit=%0d", k, NCYC);
      $fatal(1, "history overflow");
    end
    rst               = r;
    bus.valid_in      = v;
    bus.hsync_in      = hs;
    bus.vsync_in      = vs;
    bus.state         = st;
    bus.invincible    = inv;
    bus.detect_doodle = dd;
    bus.detect        = det;
    bus.rom_data      = rom;
    h_rst[k] = r; h_v[k] = v; h_hs[k] = hs; h_vs[k] = vs; h_dd[k] = dd; h_det[k] = det;

    e.idx = k;
    if (r) begin
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.det = 3'd5;
    end else begin
      if (rst_within(k - PIPE, k - 1)) begin
        pv = 1'b0; ph = 1'b1; pvs = 1'b1;
      end else begin
        pv = h_v[k-PIPE]; ph = h_hs[k-PIPE]; pvs = h_vs[k-PIPE];
      end
      if (rst_within(k - ROM_LAT, k - 1)) begin
        pd = 1'b0; pdet = 3'd5;
      end else begin
        pd = h_dd[k-ROM_LAT]; pdet = h_det[k-ROM_LAT];
      end
      if (!pv)                                    c = 12'h000;
      else if (pd && rom == KEY)                  c = BG;
      else if (pd && inv && m_frames[BLINK_BIT])  c = ~rom;
      else                                        c = rom;
`ifdef VGA_FADE_EN
      c = {fade(c[11:8], m_lvl), fade(c[7:4], m_lvl), fade(c[3:0], m_lvl)};
`endif
      e.rgb = c; e.hs = ph; e.vs = pvs; e.det = pdet;
    end
    exp_q.push_back(e);

    if (r) begin
      m_frames = 8'd0; m_vs_prev = 1'b1; m_lvl = 15; m_state = st;
    end else begin
      fall = m_vs_prev && !vs;
      if (fall) m_frames = m_frames + 8'd1;
      m_vs_prev = vs;
      if (st != m_state) begin
        m_lvl = 0; m_state = st;
      end else if (fall && m_lvl < 15) begin
        m_lvl = m_lvl + 1;
      end
    end
    k++;
  endtask

  // Monitor: every clock after an edge, compare the pins with the oldest prediction.
  initial begin
    exp_t        e;
    logic [11:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.vga_r, bus.vga_g, bus.vga_b};
        n_tests++;
        if (got !== e.rgb || bus.hsync !== e.hs || bus.vsync !== e.vs || bus.detect_out !== e.det) begin
          n_fail++;
          $display("FAIL pixel k=%0d got rgb=%h hs=%b vs=%b det=%0d expected rgb=%h hs=%b vs=%b det=%0d",
                   e.idx, got, bus.hsync, bus.vsync, bus.detect_out, e.rgb, e.hs, e.vs, e.det);
        end
      end
    end
  end

  initial begin
    logic [2:0] cur_st;
    bit         cur_inv;
    bus.valid_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.state = 3'd0;
    bus.invincible = 1'b0; bus.detect_doodle = 1'b0; bus.detect = 3'd5; bus.rom_data = 12'h000;

    // Reset with live video, then release: ABC must appear PIPE samples after release.
    repeat (3) step(1, 1, 1, 1, 3'd0, 0, 0, 3'd5, 12'hABC);
    repeat (6) step(0, 1, 1, 1, 3'd0, 0, 0, 3'd2, 12'hABC);

    // Single-pixel enable with hsync low in the same sample.
    repeat (4) step(0, 0, 1, 1, 3'd0, 0, 0, 3'd5, 12'hFFF);
    step(0, 1, 0, 1, 3'd0, 0, 0, 3'd1, 12'hFFF);
    repeat (5) step(0, 0, 1, 1, 3'd0, 0, 0, 3'd5, 12'hFFF);

    // Colour key on doodle pixels only.
    repeat (5) step(0, 1, 1, 1, 3'd0, 0, 1, 3'd5, 12'h0F0);
    repeat (5) step(0, 1, 1, 1, 3'd0, 0, 0, 3'd3, 12'h0F0);

    // Invincible blink across 20 frames, keyed pixels mixed in.
    for (int f = 0; f < 20; f++) begin
      step(0, 1, 1, 1, 3'd0, 1, 1, 3'd5, 12'h123);
      step(0, 1, 1, 1, 3'd0, 1, 1, 3'd5, 12'h123);
      step(0, 1, 1, 1, 3'd0, 1, 1, 3'd5, 12'h0F0);
      step(0, 1, 1, 0, 3'd0, 1, 1, 3'd5, 12'h123);
    end

    // State change mid-frame, fade back up over 16+ frames, then a second change.
    repeat (3) step(0, 1, 1, 1, 3'd2, 0, 0, 3'd5, 12'hFFF);
    for (int f = 0; f < 18; f++) begin
      step(0, 1, 1, 1, 3'd2, 0, 0, 3'd5, 12'hFFF);
      step(0, 1, 1, 0, 3'd2, 0, 0, 3'd5, 12'hFFF);
    end
    repeat (4) step(0, 1, 1, 1, 3'd3, 0, 0, 3'd5, 12'hFFF);
    // State change coinciding with a vsync edge.
    step(0, 1, 1, 1, 3'd3, 0, 0, 3'd5, 12'hFFF);
    step(0, 1, 1, 0, 3'd4, 0, 0, 3'd5, 12'hFFF);
    repeat (4) step(0, 1, 1, 1, 3'd4, 0, 0, 3'd5, 12'hFFF);

    // One-cycle reset mid-line with the blink phase active.
    repeat (3) step(0, 1, 1, 1, 3'd4, 1, 1, 3'd0, 12'h456);
    step(1, 1, 1, 1, 3'd4, 1, 1, 3'd0, 12'h456);
    repeat (8) step(0, 1, 1, 1, 3'd4, 1, 1, 3'd0, 12'h456);

    // Random traffic.
    cur_st  = 3'd4;
    cur_inv = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      logic [11:0] rom;
      if ($urandom_range(0, 99) == 0) cur_st = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0) cur_inv = ~cur_inv;
      rom = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 11) != 0, cur_st, cur_inv, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 5)), rom);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
